uart_top: RTL and testbench
===========================

// Module: uart_top
// PURPOSE
// - UART loopback top: 8-bit transmitter serializes a parallel byte onto an internal serial line.
// - Matching receiver, 16x oversampled, recovers the byte, checks parity and stop bit, presents result.
// - Used as a self-contained link for bring-up and protocol checks; TX and RX share one clock.
// PARAMETERS
// - PRESCALE  16  clk cycles per serial bit; even, >=8; RX oversampling ratio
// PORTS
// - clk           in   1  single clock, rising edge; TX and RX both run on it
// - rst           in   1  asynchronous, active-low reset
// - data          in   8  byte to transmit
// - data_valid    in   1  transmit request; accepted only while TX idle
// - parity_en     in   1  1: frame carries parity bit
// - parity_type   in   1  0: even parity, 1: odd parity
// - p_data        out  8  last correctly received byte
// - valid_data    out  1  1-cycle pulse: p_data updated with error-free frame
// - parity_err    out  1  1-cycle pulse: received parity mismatch
// - stop_err      out  1  1-cycle pulse: stop bit sampled 0
// - sampled_data  out  1  latest majority-voted RX sample
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0; serial line 1 (idle); TX and RX FSMs in IDLE; counters 0.
// - Frame: start(0), data[0]..data[7] LSB first, parity (only if parity_en), stop(1). Each bit = PRESCALE clks.
// - TX parity bit: even -> ^data; odd -> ~^data.
// - TX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   - In IDLE, data_valid=1 at a clk edge latches data/parity_en/parity_type; start bit drives line from next cycle.
//   - data_valid while busy is ignored.
//   - Level-held data_valid re-triggers a new frame right after STOP returns to IDLE.
// - RX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   - In IDLE, a 1->0 on the line starts the bit counter; parity_en/parity_type latched at that point.
//   - Samples taken at counts PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1 of each bit.
//   - Majority of the three samples is the bit value; sampled_data updates on the cycle after the third sample.
//   - Start bit voted 1: false start, back to IDLE, no outputs.
//   - Data bits shifted in LSB first.
//   - Parity voted value != expected: parity_err pulses 1 cycle after the parity vote; frame marked bad.
//   - Stop voted 0: stop_err pulses 1 cycle after the stop vote.
//   - Stop voted 1 and no parity error: p_data <= byte; valid_data pulses 1 cycle after the stop vote.
//   - Bad frame: p_data holds and valid_data stays 0. parity_err and stop_err may both pulse in one frame.
//   - After the stop vote RX returns to IDLE, ready for the next start edge. Rest of stop bit is not required.
// - p_data holds its value between frames.
// - Latency, data_valid edge to valid_data: (N-1)*PRESCALE + PRESCALE/2 + 3 clks; N = 10 (no parity) or 11.
// - rst asserted mid-frame: frame aborted immediately, no pulses, line idle 1.
// CONFIGURATION
// - UART_SERIAL_OUT_EN defined: adds output port tx_out (1 bit) mirroring the internal serial line, for probing.
// - UART_SERIAL_OUT_EN undefined: no tx_out port; line purely internal. Functional behaviour identical.
// TESTING
// - Reset: rst=0 -> all outputs 0, line 1; release rst, 200 clks idle -> no pulses.
// - data=0xFF, parity_en=1, parity_type=1 (odd, parity bit 1), 1-clk data_valid ->
//   p_data=0xFF, one valid_data pulse, parity_err=0, stop_err=0, latency 171 clks (PRESCALE=16).
// - data=0x7F, parity_en=0, 1-clk data_valid -> p_data=0x7F, one valid_data pulse, latency 155 clks.
// - data=0xA5, parity_en=1, parity_type=0; force RX parity bit inverted (probe/force) ->
//   parity_err pulse, no valid_data, p_data keeps previous 0x7F.
// - Force stop bit to 0 on 0x3C frame -> stop_err pulse, no valid_data.
//   Next clean frame 0x5A -> p_data=0x5A, valid.
// - data_valid pulsed again mid-frame -> ignored, exactly one valid_data.
//   Reset mid-frame -> no outputs, clean recovery on next frame.

Source files
------------

// File: rtl/uart_if.sv
// Parallel-side bundle of the UART loopback: transmit request in, received byte and status out.
interface uart_if;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_en;
  logic       parity_type;
  logic [7:0] p_data;
  logic       valid_data;
  logic       parity_err;
  logic       stop_err;
  logic       sampled_data;

  modport master (
    output data, data_valid, parity_en, parity_type,
    input  p_data, valid_data, parity_err, stop_err, sampled_data
  );

  modport slave (
    input  data, data_valid, parity_en, parity_type,
    output p_data, valid_data, parity_err, stop_err, sampled_data
  );
endinterface

// File: rtl/uart_top.sv
// UART loopback: 8-bit TX serializes onto an internal line, a 16x oversampled RX recovers the byte.
// Optional UART_SERIAL_OUT_EN adds a tx_out probe port mirroring the internal serial line.
//
// state  | meaning (same encoding for TX and RX FSMs)
// IDLE   | line idle; TX waits for data_valid, RX waits for a 1->0 edge
// START  | start bit (RX: votes it, 1 means false start)
// DATA   | eight data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop bit (RX leaves right after its vote)
module uart_top #(
  parameter int PRESCALE = 16
) (
  input  logic   clk,
  input  logic   rst,
  uart_if.slave  bus
`ifdef UART_SERIAL_OUT_EN
  ,
  output logic   tx_out
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] BIT_LAST = CW'(PRESCALE - 1);
  // Bit timers count down; RX loads one less on the detect edge so both sides stay bit-aligned.
  localparam logic [CW-1:0] DET_LOAD = CW'(PRESCALE - 2);
  localparam logic [CW-1:0] SMP_A    = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] SMP_B    = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SMP_C    = CW'(PRESCALE / 2 - 2);

  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    tx_shift;
  logic [2:0]    tx_bit;
  logic          tx_par_en;
  logic          tx_par_bit;
  logic          tx_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= ST_IDLE;
      tx_cnt     <= '0;
      tx_shift   <= '0;
      tx_bit     <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_line    <= 1'b1;
    end else if (tx_state == ST_IDLE) begin
      if (bus.data_valid) begin
        tx_state   <= ST_START;
        tx_line    <= 1'b0;
        tx_cnt     <= BIT_LAST;
        tx_shift   <= bus.data;
        tx_bit     <= '0;
        tx_par_en  <= bus.parity_en;
        tx_par_bit <= bus.parity_type ? ~^bus.data : ^bus.data;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - CW'(1);
    end else begin
      tx_cnt <= BIT_LAST;
      case (tx_state)
        ST_START: begin
          tx_state <= ST_DATA;
          tx_line  <= tx_shift[0];
        end
        ST_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_state <= tx_par_en ? ST_PARITY : ST_STOP;
            tx_line  <= tx_par_en ? tx_par_bit : 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_line  <= tx_shift[1];
          end
        end
        ST_PARITY: begin
          tx_state <= ST_STOP;
          tx_line  <= 1'b1;
        end
        default: begin
          tx_state <= ST_IDLE;
          tx_line  <= 1'b1;
          tx_cnt   <= '0;
        end
      endcase
    end
  end

  logic          rx_line;
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_shift;
  logic [2:0]    rx_bit;
  logic          rx_par_en;
  logic          rx_par_type;
  logic          line_d;
  logic          smp_a;
  logic          smp_b;
  logic          sampled;
  logic          par_chk;
  logic          stop_chk;
  logic          frame_bad;
  logic [7:0]    p_data_r;
  logic          valid_r;
  logic          par_err_r;
  logic          stop_err_r;
  logic          vote;
  logic          vote_now;
  logic          exp_par;

  assign rx_line  = tx_line;
  assign vote     = (smp_a & smp_b) | (smp_a & rx_line) | (smp_b & rx_line);
  assign vote_now = (rx_state != ST_IDLE) && (rx_cnt == SMP_C);
  assign exp_par  = rx_par_type ? ~^rx_shift : ^rx_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= ST_IDLE;
      rx_cnt      <= '0;
      rx_shift    <= '0;
      rx_bit      <= '0;
      rx_par_en   <= 1'b0;
      rx_par_type <= 1'b0;
      line_d      <= 1'b1;
      smp_a       <= 1'b0;
      smp_b       <= 1'b0;
      sampled     <= 1'b0;
      par_chk     <= 1'b0;
      stop_chk    <= 1'b0;
      frame_bad   <= 1'b0;
      p_data_r    <= '0;
      valid_r     <= 1'b0;
      par_err_r   <= 1'b0;
      stop_err_r  <= 1'b0;
    end else begin
      line_d   <= rx_line;
      par_chk  <= 1'b0;
      stop_chk <= 1'b0;
      if (rx_state != ST_IDLE) begin
        if (rx_cnt == SMP_A) smp_a <= rx_line;
        if (rx_cnt == SMP_B) smp_b <= rx_line;
        if (vote_now) sampled <= vote;
        rx_cnt <= (rx_cnt == '0) ? BIT_LAST : rx_cnt - CW'(1);
      end
      case (rx_state)
        ST_IDLE: begin
          if (line_d && !rx_line) begin
            rx_state    <= ST_START;
            rx_cnt      <= DET_LOAD;
            rx_bit      <= '0;
            rx_par_en   <= bus.parity_en;
            rx_par_type <= bus.parity_type;
            frame_bad   <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_now && vote) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
          end else if (rx_cnt == '0) begin
            rx_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (vote_now) rx_shift <= {vote, rx_shift[7:1]};
          if (rx_cnt == '0) begin
            if (rx_bit == 3'd7) rx_state <= rx_par_en ? ST_PARITY : ST_STOP;
            rx_bit <= rx_bit + 3'd1;
          end
        end
        ST_PARITY: begin
          if (vote_now) par_chk <= 1'b1;
          if (rx_cnt == '0) rx_state <= ST_STOP;
        end
        ST_STOP: begin
          // Rest of the stop bit is skipped so a back-to-back start edge is never missed.
          if (vote_now) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            stop_chk <= 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase

      valid_r    <= stop_chk & sampled & ~frame_bad;
      stop_err_r <= stop_chk & ~sampled;
      par_err_r  <= par_chk & (sampled != exp_par);
      if (stop_chk && sampled && !frame_bad) p_data_r <= rx_shift;
      if (par_chk && (sampled != exp_par)) frame_bad <= 1'b1;
    end
  end

  assign bus.p_data       = p_data_r;
  assign bus.valid_data   = valid_r;
  assign bus.parity_err   = par_err_r;
  assign bus.stop_err     = stop_err_r;
  assign bus.sampled_data = sampled;

`ifdef UART_SERIAL_OUT_EN
  assign tx_out = tx_line;
`endif

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: expected RX events are queued at stimulus time and matched
// against observed valid_data / parity_err / stop_err pulses, including arrival cycle.
module tb_uart_top;
  localparam int K_VALID = 0;
  localparam int K_PAR   = 1;
  localparam int K_STOP  = 2;

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  uart_if u_if();

`ifdef UART_SERIAL_OUT_EN
  logic tx_out;
`endif

  uart_top #(.PRESCALE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
`ifdef UART_SERIAL_OUT_EN
    ,
    .tx_out (tx_out)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t ev;
    if (rst) begin
      ev.d   = u_if.p_data;
      ev.cyc = cyc;
      if (u_if.valid_data) begin ev.kind = K_VALID; obs_q.push_back(ev); end
      if (u_if.parity_err) begin ev.kind = K_PAR;   obs_q.push_back(ev); end
      if (u_if.stop_err)   begin ev.kind = K_STOP;  obs_q.push_back(ev); end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, output int t0);
    @(negedge clk);
    u_if.data        = d;
    u_if.parity_en   = pe;
    u_if.parity_type = pt;
    u_if.data_valid  = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    u_if.data_valid = 1'b0;
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d, input int at);
    ev_t e;
    e.kind = kind;
    e.d    = d;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.data = 8'h00; u_if.data_valid = 1'b0; u_if.parity_en = 1'b0; u_if.parity_type = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({u_if.p_data, u_if.valid_data, u_if.parity_err, u_if.stop_err, u_if.sampled_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got p_data=%02h vd=%b pe=%b se=%b sd=%b, expected all 0",
               u_if.p_data, u_if.valid_data, u_if.parity_err, u_if.stop_err, u_if.sampled_data);
    end
    vectors++;
    if (dut.tx_line !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_line: got %b, expected 1", dut.tx_line);
    end
    rst = 1'b1;
    repeat (200) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0 || dut.tx_line !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_quiet: got %0d events line=%b, expected 0 events line=1", obs_q.size(), dut.tx_line);
      obs_q.delete();
    end
  endtask

  task automatic test_false_start();
    @(negedge clk);
    force dut.rx_line = 1'b0;
    repeat (3) @(negedge clk);
    release dut.rx_line;
    repeat (40) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0 || u_if.sampled_data !== 1'b1) begin
      miscompares++;
      $display("FAIL false_start: got %0d events sampled=%b, expected 0 events sampled=1",
               obs_q.size(), u_if.sampled_data);
      obs_q.delete();
    end
  endtask

  // Runs the scoreboard for one scenario; comparisons are made here for each queued expectation.
  task automatic test_frame(input string name, input logic [7:0] d, input logic pe, input logic pt,
                            input int force_kind, input logic force_val);
    int t0;
    bit ok;
    ev_t e, o;
    send(d, pe, pt, t0);
    if (force_kind == K_PAR) expect_ev(K_PAR, 8'h7F, t0 + 155);
    else if (force_kind == K_STOP) expect_ev(K_STOP, 8'h7F, t0 + 155);
    else expect_ev(K_VALID, d, t0 + (pe ? 171 : 155));
    if (force_kind != K_VALID) begin
      wait_cyc(t0 + 146);
      force dut.rx_line = force_val;
      wait_cyc(t0 + 158);
      release dut.rx_line;
    end
    wait_obs(1, 400, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: got no RX event within 400 clks, expected one", name);
    end
    repeat (30) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s_event: got nothing, expected kind=%0d data=%02h lat=%0d", name, e.kind, e.d, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.d !== e.d || o.cyc !== e.cyc) begin
          miscompares++;
          $display("FAIL %s_event: got kind=%0d data=%02h lat=%0d, expected kind=%0d data=%02h lat=%0d",
                   name, o.kind, o.d, o.cyc - t0, e.kind, e.d, e.cyc - t0);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0 || u_if.p_data !== (force_kind == K_VALID ? d : 8'h7F)) begin
      miscompares++;
      $display("FAIL %s_after: got %0d extra events p_data=%02h, expected 0 extra p_data=%02h",
               name, obs_q.size(), u_if.p_data, (force_kind == K_VALID ? d : 8'h7F));
      obs_q.delete();
    end
  endtask

  task automatic test_mid_frame_request();
    int t0;
    bit ok;
    ev_t o;
    send(8'h33, 1'b0, 1'b0, t0);
    expect_ev(K_VALID, 8'h33, t0 + 155);
    wait_cyc(t0 + 50);
    u_if.data = 8'h99; u_if.data_valid = 1'b1;
    @(negedge clk);
    u_if.data_valid = 1'b0;
    wait_obs(1, 400, ok);
    repeat (60) @(negedge clk);
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL busy_ignore_count: got %0d events, expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o.kind !== e.kind || o.d !== e.d || o.cyc !== e.cyc) begin
        miscompares++;
        $display("FAIL busy_ignore_event: got kind=%0d data=%02h lat=%0d, expected kind=%0d data=%02h lat=%0d",
                 o.kind, o.d, o.cyc - t0, e.kind, e.d, e.cyc - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int t0;
    bit ok;
    ev_t e, o;
    @(negedge clk);
    u_if.data = 8'h11; u_if.parity_en = 1'b0; u_if.parity_type = 1'b0; u_if.data_valid = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    expect_ev(K_VALID, 8'h11, t0 + 155);
    expect_ev(K_VALID, 8'h22, t0 + 161 + 155);
    @(negedge clk);
    u_if.data = 8'h22;
    wait_cyc(t0 + 161);
    u_if.data_valid = 1'b0;
    wait_obs(2, 500, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d events within budget, expected 2", obs_q.size());
    end
    repeat (30) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_event: got nothing, expected data=%02h lat=%0d", e.d, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.d !== e.d || o.cyc !== e.cyc) begin
          miscompares++;
          $display("FAIL b2b_event: got kind=%0d data=%02h lat=%0d, expected kind=%0d data=%02h lat=%0d",
                   o.kind, o.d, o.cyc - t0, e.kind, e.d, e.cyc - t0);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    send(8'h44, 1'b0, 1'b0, t0);
    wait_cyc(t0 + 80);
    rst = 1'b0;
    #1;
    vectors++;
    if (dut.tx_line !== 1'b1 || u_if.p_data !== 8'h00 || u_if.valid_data !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: got line=%b p_data=%02h vd=%b, expected line=1 p_data=00 vd=0",
               dut.tx_line, u_if.p_data, u_if.valid_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got %0d events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_false_start();
    test_frame("odd_ff", 8'hFF, 1'b1, 1'b1, K_VALID, 1'b0);
    test_frame("nopar_7f", 8'h7F, 1'b0, 1'b0, K_VALID, 1'b0);
    test_frame("parity_err", 8'hA5, 1'b1, 1'b0, K_PAR, 1'b1);
    test_frame("stop_err", 8'h3C, 1'b0, 1'b0, K_STOP, 1'b0);
    test_frame("clean_5a", 8'h5A, 1'b1, 1'b0, K_VALID, 1'b0);
    test_mid_frame_request();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame("recover_66", 8'h66, 1'b1, 1'b1, K_VALID, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end
endmodule
